// File: rtl/aes_pkg.sv
// Shared widths and FSM state encoding for the AES-CTR command sequencer.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned IV_W    = 96;
  localparam int unsigned CTR_W   = 32;
  localparam int unsigned NBLK_W  = 3;

  // Sequencer states, kept as plain constants so older flows can consume them.
  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StKey0  = 3'd1;
  localparam state_t StKey1  = 3'd2;
  localparam state_t StCtr   = 3'd3;
  localparam state_t StStart = 3'd4;
  localparam state_t StDrain = 3'd5;
  localparam state_t StDone  = 3'd6;

endpackage

// File: rtl/aes_ctr_seq.sv
// AES-CTR command sequencer: feeds key halves and counter blocks to a batch AES
// core, then XORs the returned keystream with the plaintext stream one block at a time.
module aes_ctr_seq
  import aes_pkg::*;
#(
  parameter int unsigned      MAX_BLOCKS = 4,
  parameter logic [CTR_W-1:0] CTR_INIT   = 32'd2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [KEY_W-1:0]   cmd_key,
  input  logic [IV_W-1:0]    cmd_iv,
  input  logic [NBLK_W-1:0]  cmd_nblk,
  input  logic [BLOCK_W-1:0] pt_data,
  input  logic               pt_valid,
  output logic               pt_ready,
  output logic [BLOCK_W-1:0] ct_data,
  output logic               ct_valid,
  input  logic               ct_ready,
  output logic               done,
  output logic               err,
  output logic [BLOCK_W-1:0] core_in_data,
  output logic               core_in_valid,
  input  logic               core_ready_for_inp,
  output logic               core_start,
  input  logic [BLOCK_W-1:0] core_out_data,
  input  logic               core_out_valid,
  output logic               core_ready_to_out
);

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [IV_W-1:0]     iv_q, iv_d;
  logic [NBLK_W-1:0]   nblk_q, nblk_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [NBLK_W-1:0]   cnt_q, cnt_d;
  logic                gap_q, gap_d;
  logic                err_q, err_d;
  logic [BLOCK_W-1:0]  ks_q, ks_d;
  logic                ks_full_q, ks_full_d;

  logic cmd_fire, nblk_bad, sending, beat, ks_load, ct_fire, last;

  assign cmd_ready = (state_q == StIdle);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign nblk_bad  = 32'(cmd_nblk) > MAX_BLOCKS;
  assign sending   = (state_q == StKey0) || (state_q == StKey1) || (state_q == StCtr);

  // gap_q forces an idle cycle after every beat so each beat is a lone pulse.
  assign beat          = sending && core_ready_for_inp && !gap_q;
  assign core_in_valid = beat;
  assign core_start    = (state_q == StStart);

  // Only pull from the core when the single keystream slot is free.
  assign ks_load           = (state_q == StDrain) && core_out_valid && !ks_full_q;
  assign core_ready_to_out = ks_load;

  assign ct_valid = ks_full_q && pt_valid;
  assign pt_ready = ks_full_q && ct_ready;
  assign ct_fire  = ks_full_q && pt_valid && ct_ready;
  assign ct_data  = ks_full_q ? (ks_q ^ pt_data) : '0;

  assign done = (state_q == StDone);
  assign err  = err_q;

  // Shared beat/transfer counter reaches the last block of the command.
  assign last = (cnt_q + 3'd1) == nblk_q;

  // Core input payload selected by the sending state.
  always_comb begin
    core_in_data = '0;
    case (state_q)
      StKey0:  core_in_data = key_q[KEY_W-1 -: BLOCK_W];
      StKey1:  core_in_data = key_q[BLOCK_W-1:0];
      StCtr:   core_in_data = {iv_q, ctr_q};
      default: core_in_data = '0;
    endcase
  end

  // Next-state logic for the sequencer FSM, counters and keystream slot.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    iv_d      = iv_q;
    nblk_d    = nblk_q;
    ctr_d     = ctr_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    gap_d     = beat;
    ks_d      = ks_q;
    ks_full_d = ks_full_q;

    if (ks_load) begin
      ks_d      = core_out_data;
      ks_full_d = 1'b1;
    end else if (ct_fire) begin
      ks_full_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (nblk_bad) begin
            err_d = 1'b1;
          end else begin
            key_d   = cmd_key;
            iv_d    = cmd_iv;
            nblk_d  = cmd_nblk;
            ctr_d   = CTR_INIT;
            cnt_d   = '0;
            state_d = (cmd_nblk == '0) ? StDone : StKey0;
          end
        end
      end
      StKey0: if (beat) state_d = StKey1;
      StKey1: if (beat) state_d = StCtr;
      StCtr: begin
        if (beat) begin
          ctr_d = ctr_q + 32'd1;
          if (last) begin
            cnt_d   = '0;
            state_d = StStart;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StStart: state_d = StDrain;
      StDrain: begin
        if (ct_fire) begin
          cnt_d = cnt_q + 3'd1;
          if (last) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset taking priority over any handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      key_q     <= '0;
      iv_q      <= '0;
      nblk_q    <= '0;
      ctr_q     <= CTR_INIT;
      cnt_q     <= '0;
      gap_q     <= 1'b0;
      err_q     <= 1'b0;
      ks_q      <= '0;
      ks_full_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      nblk_q    <= nblk_d;
      ctr_q     <= ctr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      ks_q      <= ks_d;
      ks_full_q <= ks_full_d;
    end
  end

endmodule

// File: tb/tb_aes_ctr_seq.sv
// Bench for aes_ctr_seq: behavioural AES-256 core stand-in, GCM reference vector,
// randomized stalls and a second instance exercising counter wrap-around.
module tb_aes_ctr_seq;

  localparam int unsigned  MaxBlocks = 4;
  localparam logic [31:0]  CtrInit   = 32'd2;
  localparam logic [127:0] GcmKeyHalf = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [95:0]  GcmIv      = 96'hcafebabefacedbaddecaf888;
  localparam logic [127:0] GcmCt0     = 128'h522dc1f099567d07f47f37a32a84427d;

  logic         clock, reset;
  logic         cmd_valid, cmd_ready;
  logic [255:0] cmd_key;
  logic [95:0]  cmd_iv;
  logic [2:0]   cmd_nblk;
  logic [127:0] pt_data, ct_data, core_in_data, core_out_data;
  logic         pt_valid, pt_ready, ct_valid, ct_ready, done, err;
  logic         core_in_valid, core_ready_for_inp, core_start, core_out_valid, core_ready_to_out;

  logic         w_cmd_valid, w_cmd_ready, w_pt_ready, w_ct_valid, w_done, w_err;
  logic [255:0] w_cmd_key;
  logic [95:0]  w_cmd_iv;
  logic [127:0] w_ct_data, w_core_in_data;
  logic         w_core_in_valid, w_core_start, w_core_ready_to_out;

  aes_ctr_seq #(.MAX_BLOCKS(MaxBlocks), .CTR_INIT(CtrInit)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_iv(cmd_iv), .cmd_nblk(cmd_nblk), .pt_data(pt_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .ct_data(ct_data), .ct_valid(ct_valid),
    .ct_ready(ct_ready), .done(done), .err(err), .core_in_data(core_in_data),
    .core_in_valid(core_in_valid), .core_ready_for_inp(core_ready_for_inp),
    .core_start(core_start), .core_out_data(core_out_data),
    .core_out_valid(core_out_valid), .core_ready_to_out(core_ready_to_out)
  );

  aes_ctr_seq #(.MAX_BLOCKS(MaxBlocks), .CTR_INIT(32'hFFFF_FFFE)) dut_wrap (
    .clock(clock), .reset(reset), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_key(w_cmd_key), .cmd_iv(w_cmd_iv), .cmd_nblk(3'd4), .pt_data(128'd0),
    .pt_valid(1'b0), .pt_ready(w_pt_ready), .ct_data(w_ct_data), .ct_valid(w_ct_valid),
    .ct_ready(1'b0), .done(w_done), .err(w_err), .core_in_data(w_core_in_data),
    .core_in_valid(w_core_in_valid), .core_ready_for_inp(1'b1),
    .core_start(w_core_start), .core_out_data(128'd0),
    .core_out_valid(1'b0), .core_ready_to_out(w_core_ready_to_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- AES-256 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  function automatic logic [127:0] aes256(input logic [255:0] key, input logic [127:0] blk);
    logic [31:0]  w [60];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] rk, res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    rk = {w[0], w[1], w[2], w[3]};
    for (int i = 0; i < 16; i++) st[i] = blk[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) tmp[q+4*c] = st[q + 4*((c+q)%4)];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ---------------- bench state ----------------
  typedef struct {
    bit         gcm;
    logic [2:0] nblk;
    int         stall;
    int         exp_done;
    int         exp_err;
    int         exp_nbeats;
  } vec_t;

  vec_t         vecs [8];
  int           checks = 0, errors = 0;
  int           cyc = 0, stall_pct = 0;
  bit           rst_req, cmd_req, w_cmd_req, held, prev_civ, busy;
  logic [127:0] in_q[$], out_q[$], ct_q[$], w_in_q[$];
  logic [127:0] pt_blk [8];
  logic [255:0] cur_key;
  logic [95:0]  cur_iv;
  int           n_done, n_err, n_start, start_beats, proto_bad, w_nstart;
  int           cmd_cyc, done_cyc, err_cyc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit go(input int p);
    return int'($urandom_range(99)) >= p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive at the falling edge, observe the handshakes of the next rising edge.
  task automatic cycle();
    logic [255:0] ckey;
    @(negedge clock);
    reset              = rst_req;
    cmd_valid          = cmd_req;
    w_cmd_valid        = w_cmd_req;
    core_ready_for_inp = go(stall_pct);
    core_out_valid     = (out_q.size() != 0) && go(stall_pct);
    core_out_data      = (out_q.size() != 0) ? out_q[0] : '0;
    pt_valid           = go(stall_pct);
    pt_data            = pt_blk[ct_q.size() % 8];
    ct_ready           = go(stall_pct);
    #1;
    cyc++;
    if (reset) begin
      held = 0; prev_civ = 0; busy = 0;
      out_q.delete();
    end else begin
      if (busy && cmd_ready) proto_bad++;
      if (cmd_valid && cmd_ready) begin
        cmd_req = 0;
        cmd_cyc = cyc;
        busy    = (32'(cmd_nblk) <= MaxBlocks);
      end
      if (core_in_valid) begin
        if (!core_ready_for_inp || prev_civ) proto_bad++;
        in_q.push_back(core_in_data);
      end
      prev_civ = core_in_valid;
      if (core_start) begin
        n_start++;
        start_beats = in_q.size();
        if (in_q.size() >= 2) begin
          ckey = {in_q[0], in_q[1]};
          for (int i = 2; i < in_q.size(); i++) out_q.push_back(aes256(ckey, in_q[i]));
        end
      end
      if (ct_valid !== (held && pt_valid) || pt_ready !== (held && ct_ready)) proto_bad++;
      if (core_ready_to_out && (held || !core_out_valid)) proto_bad++;
      if (ct_valid && ct_ready) begin
        ct_q.push_back(ct_data);
        held = 0;
      end
      if (core_ready_to_out && core_out_valid) begin
        void'(out_q.pop_front());
        held = 1;
      end
      if (done) busy = 0;
      if (w_cmd_valid && w_cmd_ready) w_cmd_req = 0;
      if (w_core_in_valid) w_in_q.push_back(w_core_in_data);
      if (w_core_start) w_nstart++;
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (err)  begin n_err++;  err_cyc  = cyc; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'd1);
    chk({tag, " ctrl outputs"}, 128'({core_in_valid, core_start, core_ready_to_out, ct_valid,
                                      pt_ready, done, err}), 128'd0);
    chk({tag, " core_in_data"}, core_in_data, 128'd0);
    chk({tag, " ct_data"}, ct_data, 128'd0);
  endtask

  task automatic prep_vec(input int k);
    vec_t v = vecs[k];
    for (int i = 0; i < 8; i++) pt_blk[i] = rnd128();
    if (v.gcm) begin
      cur_key   = {GcmKeyHalf, GcmKeyHalf};
      cur_iv    = GcmIv;
      pt_blk[0] = 128'hd9313225f88406e5a55909c5aff5269a;
      pt_blk[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
      pt_blk[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
      pt_blk[3] = 128'hb16aedf5aa0de657ba637b391aafd255;
    end else begin
      cur_key = {rnd128(), rnd128()};
      cur_iv  = 96'(rnd128());
    end
    cmd_key = cur_key; cmd_iv = cur_iv; cmd_nblk = v.nblk; stall_pct = v.stall;
    in_q.delete(); ct_q.delete();
    n_done = 0; n_err = 0; n_start = 0; start_beats = -1; proto_bad = 0;
    cmd_cyc = -1; done_cyc = -1; err_cyc = -1; held = 0;
  endtask

  task automatic run_vec(input int k, input string tag);
    vec_t         v = vecs[k];
    bit           fin = 0;
    logic [31:0]  ctr;
    logic [127:0] exp, act;
    int           nct;
    prep_vec(k);
    cmd_req = 1;
    for (int n = 0; n < 800 && !fin; n++) begin
      cycle();
      fin = !cmd_req && (n_done + n_err > 0);
    end
    chk({tag, " completes"}, 128'(fin), 128'd1);
    repeat (4) cycle();
    chk({tag, " done count"}, 128'(n_done), 128'(v.exp_done));
    chk({tag, " err count"}, 128'(n_err), 128'(v.exp_err));
    chk({tag, " core beats"}, 128'(in_q.size()), 128'(v.exp_nbeats));
    for (int i = 0; i < v.exp_nbeats; i++) begin
      ctr = CtrInit + 32'(i - 2);
      exp = (i == 0) ? cur_key[255:128] : (i == 1) ? cur_key[127:0] : {cur_iv, ctr};
      act = (i < in_q.size()) ? in_q[i] : 'x;
      chk($sformatf("%s beat%0d", tag, i), act, exp);
    end
    chk({tag, " start count"}, 128'(n_start), 128'((v.exp_nbeats > 0) ? 1 : 0));
    if (v.exp_nbeats > 0) chk({tag, " start after beats"}, 128'(start_beats), 128'(v.exp_nbeats));
    nct = v.exp_done ? int'(v.nblk) : 0;
    chk({tag, " ct count"}, 128'(ct_q.size()), 128'(nct));
    for (int i = 0; i < nct; i++) begin
      ctr = CtrInit + 32'(i);
      exp = aes256(cur_key, {cur_iv, ctr}) ^ pt_blk[i];
      act = (i < ct_q.size()) ? ct_q[i] : 'x;
      chk($sformatf("%s ct%0d", tag, i), act, exp);
    end
    if (v.gcm) chk({tag, " ct0 vector"}, (ct_q.size() > 0) ? ct_q[0] : 'x, GcmCt0);
    chk({tag, " protocol"}, 128'(proto_bad), 128'd0);
    if (v.exp_err != 0) chk({tag, " err latency"}, 128'(err_cyc - cmd_cyc), 128'd1);
    if (v.nblk == 3'd0) chk({tag, " done latency"}, 128'(done_cyc - cmd_cyc), 128'd1);
  endtask

  initial begin
    logic [31:0] wexp [4];
    bit          ok;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int u = 1; u < 256; u++) if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
      sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    vecs[0] = '{1'b1, 3'd4, 0,  1, 0, 6};
    vecs[1] = '{1'b1, 3'd4, 50, 1, 0, 6};
    vecs[2] = '{1'b0, 3'd0, 20, 1, 0, 0};
    vecs[3] = '{1'b0, 3'd5, 0,  0, 1, 0};
    vecs[4] = '{1'b0, 3'd3, 30, 1, 0, 5};
    vecs[5] = '{1'b0, 3'd1, 60, 1, 0, 3};
    vecs[6] = '{1'b0, 3'd7, 0,  0, 1, 0};
    vecs[7] = '{1'b0, 3'd2, 70, 1, 0, 4};

    reset = 1'b1; cmd_valid = 1'b0; cmd_key = '0; cmd_iv = '0; cmd_nblk = '0;
    pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b0; core_ready_for_inp = 1'b0;
    core_out_data = '0; core_out_valid = 1'b0; w_cmd_valid = 1'b0;
    w_cmd_key = '0; w_cmd_iv = '0;
    rst_req = 1; cmd_req = 0; w_cmd_req = 0; held = 0; prev_civ = 0; busy = 0;
    w_nstart = 0; proto_bad = 0; n_done = 0; n_err = 0;
    for (int i = 0; i < 8; i++) pt_blk[i] = '0;

    repeat (3) cycle();
    rst_req = 0;
    cycle();
    check_reset_outputs("reset");

    for (int k = 0; k < 8; k++) run_vec(k, $sformatf("v%0d", k));

    // Counter wrap on the instance whose first counter is FFFFFFFE.
    wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF; wexp[2] = 32'h0; wexp[3] = 32'h1;
    w_cmd_key = {rnd128(), rnd128()};
    w_cmd_iv  = 96'(rnd128());
    w_in_q.delete();
    w_cmd_req = 1;
    for (int n = 0; n < 60 && w_nstart == 0; n++) cycle();
    chk("wrap beats", 128'(w_in_q.size()), 128'd6);
    chk("wrap start", 128'(w_nstart), 128'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("wrap ctr%0d", i), (i + 2 < w_in_q.size()) ? w_in_q[i+2] : 'x,
          {w_cmd_iv, wexp[i]});

    // Reset while draining abandons the command silently.
    prep_vec(1);
    cmd_req = 1;
    ok = 0;
    for (int n = 0; n < 800 && !ok; n++) begin
      cycle();
      ok = (ct_q.size() >= 2);
    end
    chk("abort reached drain", 128'(ok), 128'd1);
    rst_req = 1;
    cycle();
    rst_req = 0;
    cycle();
    check_reset_outputs("abort");
    repeat (5) cycle();
    chk("abort no done", 128'(n_done), 128'd0);
    chk("abort no err", 128'(n_err), 128'd0);
    run_vec(0, "after abort");
    run_vec(1, "after abort stalls");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
